sram_slave_responder: RTL and testbench
=======================================

Name: sram_slave_responder

Overview:
- Responder on the data-side SRAM-like interface that the CPU top drives as initiator (en, 4-bit byte write enable, 32-bit addr/wdata, 32-bit rdata).
- Serves a word-addressed on-chip RAM plus a small memory-mapped register window: LED, switch input, scratch and free-running timer.
- Fixed one-cycle synchronous read latency, so the CPU pipeline samples rdata in the stage after it issues the request.
- No stall or ready signal exists: every request completes in one cycle.

Parameters:
- ADDR_W, 14: RAM depth is 2**ADDR_W 32-bit words, indexed by addr[ADDR_W+1:2].
- MMIO_BASE, 16'hbfaf: value of addr[31:16] that selects the register window instead of RAM.
- SW_W, 8: width of the switch input.
- LED_W, 16: width of the LED output.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- resetn  in  1  synchronous, active-low reset.
- en  in  1  request valid this cycle.
- wen  in  4  byte write enables; wen[i] writes wdata[8i+7:8i]; 0 = read.
- addr  in  32  byte address; addr[1:0] ignored.
- wdata  in  32  write data.
- rdata  out  32  read data, registered, valid the cycle after en.
- switch  in  SW_W  asynchronous switch levels.
- led  out  LED_W  LED register value.

Behaviour:
- Reset (resetn=0 at posedge): rdata=0, led=0, timer=0, scratch=0, both switch sync flops=0. RAM contents are not reset.
- Decode: mmio_sel = (addr[31:16]==MMIO_BASE). Otherwise the request targets RAM word addr[ADDR_W+1:2]. Upper RAM address bits are ignored, so RAM aliases.
- MMIO offsets (addr[15:0]):
  - 16'hf000 LED: RW, low LED_W bits stored; upper bits read 0.
  - 16'hf004 SWITCH: RO, zero-extended two-flop-synchronised value; writes ignored.
  - 16'hf008 SCRATCH: RW, 32-bit.
  - 16'he000 TIMER: RW, 32-bit.
  - Any other offset reads 0; writes to it are ignored.
- Read: when en=1, rdata <= selected word at the next posedge. When en=0, rdata holds its value.
- Write: when en=1 and wen!=0, only the enabled bytes of the target are updated at the posedge. The same request also produces a read, so rdata returns the pre-write (old) word. This is read-first behaviour for both RAM and MMIO.
- Timer:
  - Increments by 1 (mod 2**32, wraps 32'hffffffff -> 0) every cycle while resetn=1.
  - A write cycle to TIMER loads the byte-merged value of the old timer and wdata instead of incrementing. Counting resumes the following cycle.
  - A read returns the timer value before that edge's update.
- Switch: two-flop synchroniser. A change on switch becomes visible to reads two cycles later.
- Reset mid-request: reset has priority over everything. A pending read is dropped (rdata=0) and any write in that cycle is suppressed for MMIO registers. A RAM write in the reset cycle is also suppressed.
- en=0 with wen!=0: no write occurs.

Decomposition:
- Shared package: MMIO_BASE default and the offset constants OFF_LED, OFF_SW, OFF_SCRATCH, OFF_TIMER, shared with the CPU test programs and confreg-style software.
- One sub-module, sram_byte_array: a single-port RAM with byte write enables and registered read-first output.
- Keep sram_byte_array free of reset logic so it maps to block RAM.
- The top does address decode, MMIO registers, timer and switch sync, and muxes the RAM or registered MMIO read data into rdata via a registered select.

Test Plan:
- Reset then idle: resetn=0 for 2 cycles -> rdata=0, led=0. Read TIMER right after release -> value equals cycles elapsed since release.
- RAM byte write: write 32'h11223344 wen=4'hf to 32'h00000100. Then write 32'hAABBCCDD wen=4'b0101. Then read -> rdata=32'h11BB33DD one cycle after en.
- Read-first: write 32'hDEADBEEF to a RAM word holding 32'h0 -> rdata in the next cycle = 32'h0. Read next -> 32'hDEADBEEF.
- LED and unmapped: write 32'h0001ABCD to 32'hbfaff000 -> led=16'hABCD. Read back -> 32'h0000ABCD. Read 32'hbfaf1234 -> 0.
- Timer load and wrap: write 32'hfffffffe to 32'hbfafe000. Then read on each of the next 3 cycles -> 32'hfffffffe, 32'hffffffff, 32'h00000000.
- Switch sync and mid-op reset: set switch=8'h5A, then read 32'hbfaff004 each cycle -> 0, 0, then 32'h0000005A. Assert resetn=0 during a write to SCRATCH -> SCRATCH reads 0 after reset.

Source files
------------

// File: rtl/sram_slave_responder_pkg.sv
// Shared constants for the data-side SRAM responder and the
// confreg-style register window used by the CPU test programs.
package sram_slave_responder_pkg;

    localparam int          DATA_W        = 32;
    localparam logic [15:0] MMIO_BASE_DEF = 16'hbfaf;

    localparam logic [15:0] OFF_LED     = 16'hf000;
    localparam logic [15:0] OFF_SW      = 16'hf004;
    localparam logic [15:0] OFF_SCRATCH = 16'hf008;
    localparam logic [15:0] OFF_TIMER   = 16'he000;

    typedef enum logic {
        SRC_MMIO = 1'b0,
        SRC_RAM  = 1'b1
    } rd_src_e;

    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [3:0]        be
    );
        logic [DATA_W-1:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sram_slave_responder_if.sv
// SRAM-like data bus between the CPU (master) and the responder (slave).
interface sram_slave_responder_if;
    import sram_slave_responder_pkg::*;

    logic              en;
    logic [3:0]        wen;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (output en, wen, addr, wdata, input  rdata);
    modport slave  (input  en, wen, addr, wdata, output rdata);

endinterface

// File: rtl/sram_slave_responder_byte_array.sv
// Single-port RAM, byte write enables, registered read-first output.
module sram_byte_array
    import sram_slave_responder_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic [3:0]        we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // No reset here so the array stays a plain block RAM.
    always_ff @(posedge clk) begin
        if (en_i) begin
            rdata_q <= mem[addr_i];
            for (int i = 0; i < 4; i++) begin
                if (we_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_slave_responder.sv
// Data-side responder: on-chip RAM plus LED/switch/scratch/timer
// registers, one-cycle registered read latency, read-first writes.
module sram_slave_responder
    import sram_slave_responder_pkg::*;
#(
    parameter int          ADDR_W    = 14,
    parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEF,
    parameter int          SW_W      = 8,
    parameter int          LED_W     = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    sram_slave_responder_if.slave bus,
    input  logic [SW_W-1:0]      switch,
    output logic [LED_W-1:0]     led
);

    logic              mmio_sel;
    logic [15:0]       off;
    logic              wr;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] mmio_rdata;

    logic [LED_W-1:0]  led_q, led_d;
    logic [DATA_W-1:0] scratch_q, scratch_d;
    logic [DATA_W-1:0] timer_q, timer_d;
    logic [SW_W-1:0]   sw1_q, sw2_q;
    logic [DATA_W-1:0] mmio_rdata_q;
    rd_src_e           src_q;

    assign mmio_sel = (bus.addr[31:16] == MMIO_BASE);
    assign off      = bus.addr[15:0];
    // Reset suppresses every write, RAM included.
    assign wr       = bus.en && (bus.wen != 4'b0) && resetn;
    assign ram_en   = bus.en && !mmio_sel && resetn;
    assign ram_we   = (wr && !mmio_sel) ? bus.wen : 4'b0;

    sram_byte_array #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (bus.addr[ADDR_W+1:2]),
        .wdata_i (bus.wdata),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        mmio_rdata = '0;
        case (off)
            OFF_LED:     mmio_rdata = DATA_W'(led_q);
            OFF_SW:      mmio_rdata = DATA_W'(sw2_q);
            OFF_SCRATCH: mmio_rdata = scratch_q;
            OFF_TIMER:   mmio_rdata = timer_q;
            default:     mmio_rdata = '0;
        endcase
    end

    always_comb begin
        led_d     = led_q;
        scratch_d = scratch_q;
        timer_d   = timer_q + 32'd1;
        if (wr && mmio_sel) begin
            case (off)
                OFF_LED: led_d = LED_W'(byte_merge(DATA_W'(led_q),
                                                   bus.wdata, bus.wen));
                OFF_SCRATCH: scratch_d = byte_merge(scratch_q,
                                                    bus.wdata, bus.wen);
                OFF_TIMER: timer_d = byte_merge(timer_q,
                                                bus.wdata, bus.wen);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            led_q        <= '0;
            scratch_q    <= '0;
            timer_q      <= '0;
            sw1_q        <= '0;
            sw2_q        <= '0;
            mmio_rdata_q <= '0;
            src_q        <= SRC_MMIO;
        end else begin
            led_q     <= led_d;
            scratch_q <= scratch_d;
            timer_q   <= timer_d;
            sw1_q     <= switch;
            sw2_q     <= sw1_q;
            if (bus.en) begin
                mmio_rdata_q <= mmio_rdata;
                src_q        <= mmio_sel ? SRC_MMIO : SRC_RAM;
            end
        end
    end

    assign bus.rdata = (src_q == SRC_RAM) ? ram_rdata : mmio_rdata_q;
    assign led       = led_q;

endmodule

// File: tb/tb_sram_slave_responder.sv
// Directed bench for sram_slave_responder.
module tb_sram_slave_responder;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] switch;
    logic [15:0] led;
    int checks = 0;
    int failures = 0;

    sram_slave_responder_if bus();

    sram_slave_responder dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus),
        .switch (switch),
        .led    (led)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic e, input logic [3:0] w,
                       input logic [31:0] a, input logic [31:0] d);
        bus.en    = e;
        bus.wen   = w;
        bus.addr  = a;
        bus.wdata = d;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        req(1'b0, 4'h0, 32'h0, 32'h0);
        step();
        step();
        checks++;
        if (bus.rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata got=%h exp=%h", bus.rdata, 32'h0);
        end
        checks++;
        if (led !== 16'h0) begin
            failures++;
            $display("FAIL reset_led got=%h exp=%h", led, 16'h0);
        end
        resetn = 1'b1;
        req(1'b1, 4'h0, 32'hbfafe000, 32'h0);
        step();
        checks++;
        if (bus.rdata !== 32'h0) begin
            failures++;
            $display("FAIL timer_first got=%h exp=%h", bus.rdata, 32'h0);
        end
        step();
        checks++;
        if (bus.rdata !== 32'h1) begin
            failures++;
            $display("FAIL timer_second got=%h exp=%h", bus.rdata, 32'h1);
        end
    endtask

    task automatic test_ram_bytes();
        req(1'b1, 4'hf, 32'h00000100, 32'h11223344);
        step();
        req(1'b1, 4'b0101, 32'h00000100, 32'hAABBCCDD);
        step();
        req(1'b1, 4'h0, 32'h00000100, 32'h0);
        step();
        checks++;
        if (bus.rdata !== 32'h11BB33DD) begin
            failures++;
            $display("FAIL ram_bytes got=%h exp=%h", bus.rdata, 32'h11BB33DD);
        end
        req(1'b1, 4'h0, 32'h00010100, 32'h0);
        step();
        checks++;
        if (bus.rdata !== 32'h11BB33DD) begin
            failures++;
            $display("FAIL ram_alias got=%h exp=%h", bus.rdata, 32'h11BB33DD);
        end
    endtask

    task automatic test_read_first();
        req(1'b1, 4'hf, 32'h00000200, 32'h0);
        step();
        req(1'b1, 4'hf, 32'h00000200, 32'hDEADBEEF);
        step();
        checks++;
        if (bus.rdata !== 32'h0) begin
            failures++;
            $display("FAIL read_first_old got=%h exp=%h", bus.rdata, 32'h0);
        end
        req(1'b1, 4'h0, 32'h00000200, 32'h0);
        step();
        checks++;
        if (bus.rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL read_first_new got=%h exp=%h", bus.rdata, 32'hDEADBEEF);
        end
        req(1'b0, 4'hf, 32'h00000100, 32'h12345678);
        step();
        checks++;
        if (bus.rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL idle_hold got=%h exp=%h", bus.rdata, 32'hDEADBEEF);
        end
        req(1'b1, 4'h0, 32'h00000100, 32'h0);
        step();
        checks++;
        if (bus.rdata !== 32'h11BB33DD) begin
            failures++;
            $display("FAIL no_write_en0 got=%h exp=%h", bus.rdata, 32'h11BB33DD);
        end
    endtask

    task automatic test_led_unmapped();
        req(1'b1, 4'hf, 32'hbfaff000, 32'h0001ABCD);
        step();
        checks++;
        if (led !== 16'hABCD) begin
            failures++;
            $display("FAIL led_out got=%h exp=%h", led, 16'hABCD);
        end
        req(1'b1, 4'h0, 32'hbfaff000, 32'h0);
        step();
        checks++;
        if (bus.rdata !== 32'h0000ABCD) begin
            failures++;
            $display("FAIL led_read got=%h exp=%h", bus.rdata, 32'h0000ABCD);
        end
        req(1'b1, 4'hf, 32'hbfaf1234, 32'h55555555);
        step();
        req(1'b1, 4'h0, 32'hbfaf1234, 32'h0);
        step();
        checks++;
        if (bus.rdata !== 32'h0) begin
            failures++;
            $display("FAIL unmapped got=%h exp=%h", bus.rdata, 32'h0);
        end
    endtask

    task automatic test_timer();
        req(1'b1, 4'hf, 32'hbfafe000, 32'hfffffffe);
        step();
        req(1'b1, 4'h0, 32'hbfafe000, 32'h0);
        step();
        checks++;
        if (bus.rdata !== 32'hfffffffe) begin
            failures++;
            $display("FAIL timer_load got=%h exp=%h", bus.rdata, 32'hfffffffe);
        end
        step();
        checks++;
        if (bus.rdata !== 32'hffffffff) begin
            failures++;
            $display("FAIL timer_max got=%h exp=%h", bus.rdata, 32'hffffffff);
        end
        step();
        checks++;
        if (bus.rdata !== 32'h0) begin
            failures++;
            $display("FAIL timer_wrap got=%h exp=%h", bus.rdata, 32'h0);
        end
        req(1'b1, 4'b0001, 32'hbfafe000, 32'hAAAAAA55);
        step();
        checks++;
        if (bus.rdata !== 32'h1) begin
            failures++;
            $display("FAIL timer_wr_old got=%h exp=%h", bus.rdata, 32'h1);
        end
        req(1'b1, 4'h0, 32'hbfafe000, 32'h0);
        step();
        checks++;
        if (bus.rdata !== 32'h55) begin
            failures++;
            $display("FAIL timer_byte got=%h exp=%h", bus.rdata, 32'h55);
        end
    endtask

    task automatic test_switch_reset();
        switch = 8'h5A;
        req(1'b1, 4'h0, 32'hbfaff004, 32'h0);
        step();
        checks++;
        if (bus.rdata !== 32'h0) begin
            failures++;
            $display("FAIL sw_c0 got=%h exp=%h", bus.rdata, 32'h0);
        end
        step();
        checks++;
        if (bus.rdata !== 32'h0) begin
            failures++;
            $display("FAIL sw_c1 got=%h exp=%h", bus.rdata, 32'h0);
        end
        step();
        checks++;
        if (bus.rdata !== 32'h0000005A) begin
            failures++;
            $display("FAIL sw_c2 got=%h exp=%h", bus.rdata, 32'h5A);
        end
        req(1'b1, 4'hf, 32'hbfaff008, 32'hCAFEF00D);
        step();
        req(1'b1, 4'h0, 32'hbfaff008, 32'h0);
        step();
        checks++;
        if (bus.rdata !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL scratch got=%h exp=%h", bus.rdata, 32'hCAFEF00D);
        end
        resetn = 1'b0;
        req(1'b1, 4'hf, 32'hbfaff008, 32'h12345678);
        step();
        checks++;
        if (bus.rdata !== 32'h0) begin
            failures++;
            $display("FAIL rst_rdata got=%h exp=%h", bus.rdata, 32'h0);
        end
        checks++;
        if (led !== 16'h0) begin
            failures++;
            $display("FAIL rst_led got=%h exp=%h", led, 16'h0);
        end
        req(1'b1, 4'hf, 32'h00000200, 32'h00000BAD);
        step();
        resetn = 1'b1;
        req(1'b1, 4'h0, 32'hbfaff008, 32'h0);
        step();
        checks++;
        if (bus.rdata !== 32'h0) begin
            failures++;
            $display("FAIL rst_scratch got=%h exp=%h", bus.rdata, 32'h0);
        end
        req(1'b1, 4'h0, 32'h00000200, 32'h0);
        step();
        checks++;
        if (bus.rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL rst_ram_wr got=%h exp=%h", bus.rdata, 32'hDEADBEEF);
        end
    endtask

    initial begin
        switch = 8'h00;
        test_reset();
        test_ram_bytes();
        test_read_first();
        test_led_unmapped();
        test_timer();
        test_switch_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
